// File: rtl/uart_rx_deserializer.sv
// Receive-side deserializer of the 16550-style UART: oversampled start/data/parity/stop
// recovery from the RX pin, one FIFO push (or overrun pulse) per character with LSR status.
module uart_rx_deserializer #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx_i,
   input  logic [1:0] wls_i,
   input  logic       pen_i,
   input  logic       eps_i,
   input  logic       stick_parity_i,
   input  logic       rx_fifo_full_i,
   output logic       push_o,
   output logic [7:0] data_o,
   output logic       pe_o,
   output logic       fe_o,
   output logic       bi_o,
   output logic       oe_o,
   output logic       busy_o
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE + 1);
   localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                rx_s;
   logic [TICK_W-1:0]   tick_q, tick_d, tick_inc;
   logic [2:0]          bit_q, bit_d, last_bit;
   logic [7:0]          sh_q, sh_d;
   logic [1:0]          wls_q, wls_d;
   logic                pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;
   logic                par_bit_q, par_bit_d, perr_q, perr_d;
   logic                exp_par, ferr, brk;
   logic                push_q, push_d, oe_q, oe_d;
   logic                pe_q, pe_d, fe_q, fe_d, bi_q, bi_d;
   logic [7:0]          data_q, data_d;

   // Metastability synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   assign tick_inc = tick_q + TICK_W'(1);
   assign last_bit = 3'd4 + {1'b0, wls_q};
   assign exp_par  = stick_q ? ~eps_q : (eps_q ? ^sh_q : ~(^sh_q));
   assign ferr     = ~rx_s;
   assign brk      = ~rx_s && (sh_q == 8'h00) && (!pen_q || !par_bit_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         wls_q     <= '0;
         pen_q     <= 1'b0;
         eps_q     <= 1'b0;
         stick_q   <= 1'b0;
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
         push_q    <= 1'b0;
         oe_q      <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         bi_q      <= 1'b0;
         data_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         wls_q     <= wls_d;
         pen_q     <= pen_d;
         eps_q     <= eps_d;
         stick_q   <= stick_d;
         par_bit_q <= par_bit_d;
         perr_q    <= perr_d;
         push_q    <= push_d;
         oe_q      <= oe_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         bi_q      <= bi_d;
         data_q    <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      wls_d     = wls_q;
      pen_d     = pen_q;
      eps_d     = eps_q;
      stick_d   = stick_q;
      par_bit_d = par_bit_q;
      perr_d    = perr_q;
      push_d    = 1'b0;
      oe_d      = 1'b0;
      pe_d      = 1'b0;
      fe_d      = 1'b0;
      bi_d      = 1'b0;
      data_d    = data_q;

      if (baud_pulse) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d   = START;
                  tick_d    = TICK_W'(1);
                  wls_d     = wls_i;
                  pen_d     = pen_i;
                  eps_d     = eps_i;
                  stick_d   = stick_parity_i;
                  sh_d      = 8'h00;
                  par_bit_d = 1'b0;
                  perr_d    = 1'b0;
               end
            end
            START: begin
               if (tick_inc == HALF_TICK) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  tick_d = tick_inc;
               end
            end
            DATA: begin
               if (tick_inc == FULL_TICK) begin
                  tick_d        = '0;
                  sh_d[bit_q]   = rx_s;
                  if (bit_q == last_bit) state_d = pen_q ? PARITY : STOP;
                  else                   bit_d   = bit_q + 3'd1;
               end else begin
                  tick_d = tick_inc;
               end
            end
            PARITY: begin
               if (tick_inc == FULL_TICK) begin
                  tick_d    = '0;
                  par_bit_d = rx_s;
                  perr_d    = (rx_s != exp_par);
                  state_d   = STOP;
               end else begin
                  tick_d = tick_inc;
               end
            end
            STOP: begin
               // Character completes here; a full FIFO turns the push into an overrun
               if (tick_inc == FULL_TICK) begin
                  tick_d = '0;
                  pe_d   = perr_q;
                  fe_d   = ferr;
                  bi_d   = brk;
                  if (rx_fifo_full_i) begin
                     oe_d = 1'b1;
                  end else begin
                     push_d = 1'b1;
                     data_d = brk ? 8'h00 : sh_q;
                  end
                  state_d = (ferr || brk) ? WAIT_IDLE : IDLE;
               end else begin
                  tick_d = tick_inc;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign push_o = push_q;
   assign oe_o   = oe_q;
   assign pe_o   = pe_q;
   assign fe_o   = fe_q;
   assign bi_o   = bi_q;
   assign data_o = data_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: 16x oversampling with baud_pulse every clk.
module tb_uart_rx_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_pulse = 1'b1;
   logic       rx_i = 1'b1;
   logic [1:0] wls_i = 2'b11;
   logic       pen_i = 1'b0;
   logic       eps_i = 1'b0;
   logic       stick_parity_i = 1'b0;
   logic       rx_fifo_full_i = 1'b0;
   logic       push_o, pe_o, fe_o, bi_o, oe_o, busy_o;
   logic [7:0] data_o;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int push_cnt = 0, oe_cnt = 0, last_cyc = 0;
   logic [7:0] last_data = 8'h00;
   logic last_pe = 1'b0, last_fe = 1'b0, last_bi = 1'b0;
   logic oe_pe = 1'b0, oe_fe = 1'b0, oe_bi = 1'b0;

   uart_rx_deserializer #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx_i(rx_i),
      .wls_i(wls_i), .pen_i(pen_i), .eps_i(eps_i), .stick_parity_i(stick_parity_i),
      .rx_fifo_full_i(rx_fifo_full_i), .push_o(push_o), .data_o(data_o),
      .pe_o(pe_o), .fe_o(fe_o), .bi_o(bi_o), .oe_o(oe_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder sampled on the falling edge
   always @(negedge clk) begin
      if (push_o) begin
         push_cnt  <= push_cnt + 1;
         last_data <= data_o;
         last_pe   <= pe_o;
         last_fe   <= fe_o;
         last_bi   <= bi_o;
         last_cyc  <= cyc;
      end
      if (oe_o) begin
         oe_cnt <= oe_cnt + 1;
         oe_pe  <= pe_o;
         oe_fe  <= fe_o;
         oe_bi  <= bi_o;
      end
   end

   task automatic drive_bit(input logic b);
      rx_i = b;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i]);
      if (par_en) drive_bit(par_bit);
      drive_bit(stop_bit);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (push_o !== 1'b0) begin errors++; $display("FAIL reset_push got %b expected 0", push_o); end
      checks++; if (oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b expected 0", oe_o); end
      checks++; if ({pe_o, fe_o, bi_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {pe_o, fe_o, bi_o}); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
      checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", data_o); end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_8n1;
      int p0, o0, t0;
      wls_i = 2'b11; pen_i = 1'b0;
      p0 = push_cnt; o0 = oe_cnt; t0 = cyc;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL 8n1_pushes got %0d expected 1", push_cnt - p0); end
      checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data got %h expected a5", last_data); end
      checks++; if ({last_pe, last_fe, last_bi} !== 3'b000) begin errors++; $display("FAIL 8n1_flags got %b expected 000", {last_pe, last_fe, last_bi}); end
      checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL 8n1_oe got %0d expected 0", oe_cnt - o0); end
      // start drive -> 2 sync + 8 ticks to start midpoint + 9*16 to stop midpoint
      checks++; if (last_cyc - t0 !== 154) begin errors++; $display("FAIL 8n1_latency got %0d expected 154", last_cyc - t0); end
      checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL 8n1_data_hold got %h expected a5", data_o); end
   endtask

   task automatic test_parity;
      int p0;
      wls_i = 2'b10; pen_i = 1'b1; eps_i = 1'b1; stick_parity_i = 1'b0;
      p0 = push_cnt;
      send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
      idle(20);
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL par_ok_push got %0d expected 1", push_cnt - p0); end
      checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL par_ok_data got %h expected 55", last_data); end
      checks++; if (last_pe !== 1'b0) begin errors++; $display("FAIL par_ok_pe got %b expected 0", last_pe); end
      send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
      idle(20);
      checks++; if (push_cnt - p0 !== 2) begin errors++; $display("FAIL par_bad_push got %0d expected 2", push_cnt - p0); end
      checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL par_bad_data got %h expected 55", last_data); end
      checks++; if (last_pe !== 1'b1) begin errors++; $display("FAIL par_bad_pe got %b expected 1", last_pe); end
      // stick parity with eps=1 expects a 0 parity bit; sending 1 is an error
      stick_parity_i = 1'b1;
      send_frame(8'h03, 7, 1'b1, 1'b1, 1'b1);
      idle(20);
      checks++; if (last_pe !== 1'b1) begin errors++; $display("FAIL stick_pe got %b expected 1", last_pe); end
      stick_parity_i = 1'b0;
   endtask

   task automatic test_framing;
      int p0;
      wls_i = 2'b11; pen_i = 1'b0;
      p0 = push_cnt;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL fe_data got %h expected 3c", last_data); end
      checks++; if ({last_fe, last_bi} !== 2'b10) begin errors++; $display("FAIL fe_flags got %b expected 10", {last_fe, last_bi}); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL fe_wait_busy got %b expected 1", busy_o); end
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL fe_no_restart got %0d expected 1", push_cnt - p0); end
      idle(16);
      send_frame(8'hC7, 8, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++; if (push_cnt - p0 !== 2) begin errors++; $display("FAIL fe_next_push got %0d expected 2", push_cnt - p0); end
      checks++; if ({last_data, last_fe} !== {8'hC7, 1'b0}) begin errors++; $display("FAIL fe_next_frame got %h expected 18e", {last_data, last_fe}); end
   endtask

   task automatic test_break;
      int p0;
      wls_i = 2'b11; pen_i = 1'b1; eps_i = 1'b1;
      p0 = push_cnt;
      rx_i = 1'b0;
      repeat (352) @(posedge clk);
      #1;
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL brk_pushes got %0d expected 1", push_cnt - p0); end
      checks++; if (last_data !== 8'h00) begin errors++; $display("FAIL brk_data got %h expected 00", last_data); end
      checks++; if ({last_bi, last_fe, last_pe} !== 3'b110) begin errors++; $display("FAIL brk_flags got %b expected 110", {last_bi, last_fe, last_pe}); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL brk_busy got %b expected 1", busy_o); end
      checks++; if ({bi_o, fe_o} !== 2'b00) begin errors++; $display("FAIL brk_flag_clear got %b expected 00", {bi_o, fe_o}); end
      idle(30);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL brk_release_busy got %b expected 0", busy_o); end
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL brk_release_push got %0d expected 1", push_cnt - p0); end
   endtask

   task automatic test_glitch;
      int p0, o0;
      pen_i = 1'b0;
      p0 = push_cnt; o0 = oe_cnt;
      rx_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idle(40);
      checks++; if (push_cnt - p0 !== 0) begin errors++; $display("FAIL glitch_push got %0d expected 0", push_cnt - p0); end
      checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL glitch_oe got %0d expected 0", oe_cnt - o0); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b expected 0", busy_o); end
      wls_i = 2'b00;
      send_frame(8'h0F, 5, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++; if (last_data !== 8'h0F) begin errors++; $display("FAIL wls5_data got %h expected 0f", last_data); end
      send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++; if (last_data !== 8'h1F) begin errors++; $display("FAIL wls5_upper got %h expected 1f", last_data); end
      checks++; if (push_cnt - p0 !== 2) begin errors++; $display("FAIL wls5_pushes got %0d expected 2", push_cnt - p0); end
   endtask

   task automatic test_overrun;
      int p0, o0;
      wls_i = 2'b11; pen_i = 1'b0;
      p0 = push_cnt; o0 = oe_cnt;
      rx_fifo_full_i = 1'b1;
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
      idle(20);
      rx_fifo_full_i = 1'b0;
      checks++; if (push_cnt - p0 !== 0) begin errors++; $display("FAIL ovr_push got %0d expected 0", push_cnt - p0); end
      checks++; if (oe_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_oe_cycles got %0d expected 1", oe_cnt - o0); end
      checks++; if ({oe_pe, oe_fe, oe_bi} !== 3'b000) begin errors++; $display("FAIL ovr_flags got %b expected 000", {oe_pe, oe_fe, oe_bi}); end
   endtask

   task automatic test_reset_mid;
      int p0;
      p0 = push_cnt;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b expected 1", busy_o); end
      rst = 1'b1;
      #2;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b expected 0", busy_o); end
      checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h expected 00", data_o); end
      checks++; if ({push_o, oe_o, pe_o, fe_o, bi_o} !== 5'b0) begin errors++; $display("FAIL mid_rst_outs got %b expected 00000", {push_o, oe_o, pe_o, fe_o, bi_o}); end
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(60);
      checks++; if (push_cnt - p0 !== 0) begin errors++; $display("FAIL mid_no_push got %0d expected 0", push_cnt - p0); end
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
      idle(20);
      checks++; if (push_cnt - p0 !== 1) begin errors++; $display("FAIL mid_next_push got %0d expected 1", push_cnt - p0); end
      checks++; if (last_data !== 8'hC3) begin errors++; $display("FAIL mid_next_data got %h expected c3", last_data); end
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_parity;
      test_framing;
      test_break;
      test_glitch;
      test_overrun;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-path serializer-to-parallel stage of the 16550-style UART. Sits between the RX pin and the RX FIFO, downstream of the register/baud block.
- Consumes the shared baud tick and the LCR frame-format fields.
- Produces one FIFO push per received character, plus per-character parity, framing, break and overrun status for the LSR.

Parameters:
OVERSAMPLE, 16, baud ticks per bit period; must be even and >= 4
SYNC_STAGES, 2, flops in the rx input synchronizer; >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud_pulse  in  1  one-clk-wide tick, OVERSAMPLE ticks per bit
rx_i  in  1  serial input, asynchronous, idles high
wls_i  in  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
pen_i  in  1  parity enable
eps_i  in  1  even parity select (1=even)
stick_parity_i  in  1  stick parity
rx_fifo_full_i  in  1  RX FIFO full
push_o  out  1  one-cycle push to RX FIFO
data_o  out  8  received character, zero-extended above word length
pe_o  out  1  parity error, valid with push_o or oe_o
fe_o  out  1  framing error, valid with push_o or oe_o
bi_o  out  1  break indicator, valid with push_o or oe_o
oe_o  out  1  one-cycle overrun pulse (character dropped)
busy_o  out  1  high while not in IDLE

Behaviour:
- Reset:
  - All synchronizer flops = 1.
  - FSM = IDLE; tick and bit counters = 0.
  - push_o, oe_o, pe_o, fe_o, bi_o, busy_o = 0; data_o = 8'h00.
- Reset mid-frame aborts the frame immediately. No push is issued.
- Internal logic uses only the synchronized rx_s. FSM counters advance only in cycles where baud_pulse=1.
- IDLE:
  - On a baud_pulse with rx_s=0, go to START with tick_cnt=1.
  - Latch wls/pen/eps/stick_parity into shadow registers. LCR changes mid-frame have no effect until the next start.
- START:
  - When tick_cnt reaches OVERSAMPLE/2 (bit midpoint), sample rx_s.
  - rx_s=1 is a false start: return to IDLE with no outputs.
  - rx_s=0 goes to DATA; tick_cnt=0, bit_cnt=0.
- DATA:
  - Sample every OVERSAMPLE ticks, i.e. at each subsequent bit midpoint. LSB first into a shift register.
  - After 5+wls bits, go to PARITY if pen, else STOP.
- PARITY:
  - Sample at midpoint.
  - Expected bit:
    - stick_parity=1: expected = ~eps.
    - eps=1 (even): expected = XOR of data bits.
    - eps=0 (odd): expected = ~XOR of data bits.
  - perr = (sample != expected).
- STOP:
  - Sample the first stop bit at midpoint. Only one stop bit is checked regardless of LCR.stb.
  - ferr = (sample == 0).
  - brk = all data bits, the parity bit (if enabled) and the stop bit sampled 0. When brk=1, data_o = 8'h00.
- Completion, on the clk edge after the STOP-sampling baud_pulse:
  - If rx_fifo_full_i=0: push_o=1 for exactly one cycle, with data_o/pe_o/fe_o/bi_o valid in that same cycle.
  - If rx_fifo_full_i=1: push_o stays 0 and oe_o=1 for one cycle. pe_o/fe_o/bi_o still report the dropped character. data_o is not meaningful.
  - pe_o/fe_o/bi_o/oe_o return to 0 the following cycle. data_o holds its value until the next completion.
  - Next state: if ferr or brk, go to WAIT_IDLE; else go to IDLE.
- WAIT_IDLE: stay until a baud_pulse with rx_s=1, then go to IDLE. This prevents a held-low line from generating repeated characters.
- A new start bit may be detected on the first baud_pulse after return to IDLE. There is no dead time beyond that.
- Upper data bits above the word length are 0 in data_o.
- busy_o is combinational from state: 0 in IDLE only.

Test Plan:
- OVERSAMPLE=16, baud_pulse every clk, wls=11, pen=0, send 8N1 0xA5 -> one push_o pulse, data_o=8'hA5, pe/fe/bi/oe=0; push 1 clk after stop-midpoint tick.
- wls=10, pen=1, eps=1, send 7E1 0x55 with correct parity 0 -> data_o=8'h55, pe_o=0. Repeat with parity bit 1 -> pe_o=1, data still pushed.
- 8N1, send 0x3C with stop bit forced 0 -> push data_o=8'h3C, fe_o=1. No new frame until rx returns high; a second start immediately after is only accepted once rx_s=1 has been seen.
- Hold rx low for 2 full frame times (wls=11, pen=1) -> exactly one push, data_o=8'h00, bi_o=1, fe_o=1; FSM waits in WAIT_IDLE, busy_o=1 until line high.
- Glitch rx low for 5 ticks then high -> no push, no flags, FSM back in IDLE. Then a valid 0x0F with wls=00 -> data_o=8'h0F (5 bits, upper bits 0).
- Frame 0x81 completes with rx_fifo_full_i=1 -> push_o=0, oe_o pulses 1 cycle. Assert rst mid-way through the next frame -> all outputs 0, no push after release, next clean frame received correctly.
